// File: rtl/pixel_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_packer_pkg
// Description : Shared widths and state encoding for the pixel packer.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_packer_pkg;

    localparam int PixelWidth = 12;
    localparam int WordWidth  = 16;
    localparam int AccWidth   = 24;
    localparam int NbitsWidth = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_packer
// Description : Pops 12-bit pixels from the FIFO read port and packs them
//               LSB-first into 16-bit words on a valid/ready stream, with an
//               end-of-frame flush that emits a zero-padded partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_packer
    import pixel_packer_pkg::*;
#(
    parameter int WordCountWidth = 24
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_rempty,
    input  logic [PixelWidth-1:0]     fifo_rd,
    output logic                      fifo_r,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [WordWidth-1:0]      out_data,
    input  logic                      out_ready,
    output logic                      flush_done,
    output logic [WordCountWidth-1:0] word_count
);

    localparam logic [NbitsWidth-1:0] c_word_bits = NbitsWidth'(WordWidth);
    localparam logic [NbitsWidth-1:0] c_pix_bits  = NbitsWidth'(PixelWidth);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [AccWidth-1:0]       r_acc;
    logic [AccWidth-1:0]       w_acc_shift;
    logic [AccWidth-1:0]       w_acc_nxt;
    logic [NbitsWidth-1:0]     r_nbits;
    logic [NbitsWidth-1:0]     w_nbits_nxt;
    logic [NbitsWidth-1:0]     w_emit_bits;
    logic [NbitsWidth-1:0]     w_rem;
    logic [WordCountWidth-1:0] r_word_count;
    logic                      w_accept;
    logic                      w_pop;

    // Upper accumulator bits are always zero, so acc[15:0] is already the
    // zero-padded partial word during a flush.
    always_comb begin
        out_valid = 1'b0;
        case (r_state)
            RUN:     out_valid = (r_nbits >= c_word_bits);
            FLUSH:   out_valid = (r_nbits != '0);
            default: out_valid = 1'b0;
        endcase
    end

    assign out_data   = r_acc[WordWidth-1:0];
    assign w_accept   = out_valid & out_ready;
    assign flush_done = (r_state == DONE);
    assign word_count = r_word_count;
    assign fifo_r     = w_pop;

    always_comb begin
        w_emit_bits = '0;
        if (w_accept) begin
            w_emit_bits = (r_nbits < c_word_bits) ? r_nbits : c_word_bits;
        end
        w_rem       = r_nbits - w_emit_bits;
        // Only pop when the pixel fits beside what survives this cycle's emit.
        w_pop       = (r_state == RUN) & ~fifo_rempty & (w_rem <= c_pix_bits) & ~rst;
        w_acc_shift = w_accept ? (r_acc >> WordWidth) : r_acc;
        w_acc_nxt   = w_acc_shift;
        if (w_pop) begin
            w_acc_nxt = w_acc_shift | ({{(AccWidth-PixelWidth){1'b0}}, fifo_rd} << w_rem);
        end
        w_nbits_nxt = w_rem + (w_pop ? c_pix_bits : '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (flush) w_state_nxt = FLUSH;
            // Leave as soon as the last word is being accepted, so the done
            // pulse lands on the cycle right after that accept.
            FLUSH:   if (w_nbits_nxt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_acc        <= '0;
            r_nbits      <= '0;
            r_word_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_nbits <= w_nbits_nxt;
            if (w_accept && (r_word_count != '1)) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_packer.sv
`default_nettype none
// Bench for pixel_packer: table vectors, hand-written flush/stall/reset
// sequences and a randomized stream checked against a bit-queue model.
module tb_pixel_packer;

    typedef struct packed {
        logic [3:0][11:0] pix;
        logic [2:0][15:0] words;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, fifo_rempty, fifo_r, fifo_r4, flush, out_ready;
    logic        out_valid, out_valid4, flush_done, flush_done4;
    logic [11:0] fifo_rd;
    logic [15:0] out_data, out_data4;
    logic [23:0] word_count;
    logic [3:0]  word_count4;

    logic [11:0] src_q[$];
    logic [15:0] rx_q[$];
    logic [15:0] exp_q[$];
    bit          mbits[$];

    int checks = 0, errors = 0;
    int pops = 0, accepts = 0, fdone_cnt = 0, bad_pop = 0, diverge = 0;

    always #5 clk = ~clk;

    pixel_packer #(.WordCountWidth(24)) dut (
        .clk(clk), .rst(rst), .fifo_rempty(fifo_rempty), .fifo_rd(fifo_rd),
        .fifo_r(fifo_r), .flush(flush), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .flush_done(flush_done), .word_count(word_count)
    );

    pixel_packer #(.WordCountWidth(4)) dut4 (
        .clk(clk), .rst(rst), .fifo_rempty(fifo_rempty), .fifo_rd(fifo_rd),
        .fifo_r(fifo_r4), .flush(flush), .out_valid(out_valid4), .out_data(out_data4),
        .out_ready(out_ready), .flush_done(flush_done4), .word_count(word_count4)
    );

    // FIFO model: head presented between edges, consumed on a popping edge.
    initial begin
        fifo_rempty = 1'b1;
        fifo_rd     = '0;
        forever begin
            @(negedge clk);
            fifo_rempty = (src_q.size() == 0);
            fifo_rd     = fifo_rempty ? 12'h000 : src_q[0];
        end
    end

    initial forever begin
        @(posedge clk);
        if (fifo_r && fifo_rempty) bad_pop++;
        if (fifo_r4 !== fifo_r || out_valid4 !== out_valid ||
            out_data4 !== out_data || flush_done4 !== flush_done) diverge++;
        if (fifo_r && src_q.size() > 0) begin
            void'(src_q.pop_front());
            pops++;
        end
        if (rst) accepts = 0;
        else if (out_valid && out_ready) begin
            rx_q.push_back(out_data);
            accepts++;
        end
        if (flush_done) fdone_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: a plain bit stream, LSB-first, cut into 16-bit words.
    task automatic model_push(input logic [11:0] p);
        for (int i = 0; i < 12; i++) mbits.push_back(p[i]);
        while (mbits.size() >= 16) begin
            logic [15:0] w;
            for (int i = 0; i < 16; i++) w[i] = mbits.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic model_flush();
        logic [15:0] w;
        int n;
        w = '0;
        n = mbits.size();
        if (n > 0) begin
            for (int i = 0; i < n; i++) w[i] = mbits.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic push(input logic [11:0] p);
        src_q.push_back(p);
        model_push(p);
    endtask

    task automatic wait_drain(input string name, input int want);
        int n;
        n = 0;
        while ((src_q.size() != 0 || rx_q.size() < want) && n < 3000) begin
            tick(1);
            n++;
        end
        tick(2);
        check({name, " drain"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic compare_stream(input string name);
        check({name, " word count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rx_q.size() > 0)
            check(name, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic wait_fdone(input int f0);
        int n;
        n = 0;
        while (fdone_cnt == f0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(3);
        check("flush_done pulses", 32'(fdone_cnt - f0), 32'd1);
    endtask

    vec_t vecs [4];
    int   p0, f0, stable, npushed;

    initial begin
        vecs[0].pix = {12'hABC, 12'h789, 12'h456, 12'h123};
        vecs[0].words = {16'hABC7, 16'h8945, 16'h6123};
        vecs[1].pix = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        vecs[1].words = {16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[2].pix = {12'hFFF, 12'h000, 12'hFFF, 12'h000};
        vecs[2].words = {16'hFFF0, 16'h00FF, 16'hF000};
        vecs[3].pix = {12'h100, 12'h00F, 12'h800, 12'h001};
        vecs[3].words = {16'h1000, 16'h0F80, 16'h0001};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        tick(3);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset fifo_r", 32'(fifo_r), 32'd0);
        check("reset flush_done", 32'(flush_done), 32'd0);
        check("reset word_count", 32'(word_count), 32'd0);
        rst = 1'b0;
        tick(2);

        // Table vectors: four pixels in, three known words out.
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            p0 = pops;
            for (int j = 0; j < 4; j++) src_q.push_back(vecs[v].pix[j]);
            wait_drain($sformatf("vec%0d", v), 3);
            for (int j = 0; j < 3; j++)
                check($sformatf("vec%0d word%0d", v, j), 32'(rx_q[j]), 32'(vecs[v].words[j]));
            check($sformatf("vec%0d pops", v), 32'(pops - p0), 32'd4);
            check($sformatf("vec%0d word_count", v), 32'(word_count), 32'(3 * (v + 1)));
            rx_q.delete();
        end

        // Full-rate throughput: one pop every cycle.
        for (int i = 0; i < 40; i++) push(12'($urandom_range(0, 4095)));
        tick(2);
        p0 = pops;
        tick(12);
        check("throughput pops", 32'(pops - p0), 32'd12);
        wait_drain("throughput", exp_q.size());
        compare_stream("throughput");
        check("word_count vs accepts", 32'(word_count), 32'(accepts));

        // Flush with a partial word pending.
        push(12'h123);
        push(12'h456);
        wait_drain("flush partial", 1);
        f0 = fdone_cnt;
        pulse_flush();
        model_flush();
        wait_fdone(f0);
        check("flush word0", 32'(rx_q[0]), 32'h6123);
        check("flush word1", 32'(rx_q[1]), 32'h0045);
        compare_stream("flush partial");

        // Flush of an empty buffer.
        pulse_flush();
        check("empty flush k+1", 32'(flush_done), 32'd0);
        tick(1);
        check("empty flush k+2", 32'(flush_done), 32'd1);
        tick(1);
        check("empty flush k+3", 32'(flush_done), 32'd0);
        check("empty flush words", 32'(rx_q.size()), 32'd0);

        // Backpressure: only two pops, head word held steady.
        out_ready = 1'b0;
        p0 = pops;
        for (int r = 0; r < 2; r++) begin
            push(12'h123); push(12'h456); push(12'h789); push(12'hABC);
        end
        tick(12);
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_data == 16'h6123) stable++;
            tick(1);
        end
        check("stall held word", 32'(stable), 32'd10);
        check("stall pops", 32'(pops - p0), 32'd2);
        check("stall fifo_r", 32'(fifo_r), 32'd0);
        out_ready = 1'b1;
        wait_drain("stall", exp_q.size());
        compare_stream("stall");

        // Reset mid-stream discards the leftover bits.
        push(12'h123); push(12'h456); push(12'h789);
        wait_drain("pre-reset", exp_q.size());
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset word_count", 32'(word_count), 32'd0);
        rx_q.delete(); exp_q.delete(); mbits.delete();
        push(12'h123); push(12'h456); push(12'h789); push(12'hABC);
        wait_drain("post-reset", exp_q.size());
        check("post-reset word0", 32'(rx_q[0]), 32'h6123);
        compare_stream("post-reset");
        check("post-reset word_count", 32'(word_count), 32'd3);

        // Randomized stream with random backpressure, ended by a flush.
        npushed = 0;
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (npushed < 301 && $urandom_range(0, 2) == 0) begin
                push(12'($urandom_range(0, 4095)));
                npushed++;
            end
            tick(1);
        end
        while (npushed < 301) begin
            push(12'($urandom_range(0, 4095)));
            npushed++;
        end
        out_ready = 1'b1;
        wait_drain("random", exp_q.size());
        f0 = fdone_cnt;
        pulse_flush();
        model_flush();
        wait_fdone(f0);
        compare_stream("random");
        check("random word_count", 32'(word_count), 32'(accepts));

        check("saturated word_count", 32'(word_count4), 32'd15);
        check("pop while empty", 32'(bad_pop), 32'd0);
        check("narrow counter instance agreement", 32'(diverge), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_packer.md
# pixel_packer

Read-side consumer of the pixel async FIFO, in the `clk` domain. Pops 12-bit pixels from the FIFO read port and packs them densely, LSB-first, into 16-bit words: 4 pixels become 3 words, with no padding between pixels. Delivers the words over a valid/ready stream to the RAM-write path. Supports an end-of-frame flush that emits a final zero-padded partial word.

## Interface
- `WordCountWidth`, default 24: width of the accepted-word counter.
- `clk` in 1: system clock; the FIFO read clock.
- `rst` in 1: synchronous, active-high reset.
- `fifo_rempty` in 1: FIFO empty flag.
- `fifo_rd` in 12: FIFO head pixel; valid whenever `!fifo_rempty`.
- `fifo_r` out 1: pop strobe; the FIFO consumes the head pixel on the `clk` edge where it is high.
- `flush` in 1: single-cycle request to drain all buffered bits.
- `out_valid` out 1: `out_data` holds a word.
- `out_data` out 16: packed word.
- `out_ready` in 1: downstream accepts the word when `out_valid & out_ready`.
- `flush_done` out 1: one-cycle pulse when a flush has completed.
- `word_count` out WordCountWidth: count of accepted words; saturates at all-ones.

## Operation
- Datapath: 24-bit accumulator `acc` plus bit count `nbits`, which only takes values 0,4,…,24.
- Invariant: all `acc` bits at or above `nbits` are zero.
- Emit: when a word is accepted, `acc` shifts right 16 with zero fill and `nbits` drops by 16, or to 0 in a flush when fewer than 16 bits remain.
- Pop: the pixel is OR'd into `acc` at bit offset (`nbits` − emitted bits) and `nbits` rises by 12. Emit and pop may occur in the same cycle.
- Pop rule: `fifo_r = (state==RUN) & !fifo_rempty & ((nbits − (accept?16:0)) <= 12)`. The pixel is captured on the same edge. `fifo_r` is never high while `fifo_rempty` is high.
- Bit mapping for pixels p0..p3:
  - word0 = {p1[3:0], p0}
  - word1 = {p2[7:0], p1[11:4]}
  - word2 = {p3, p2[11:8]}
- State machine:
  - RUN: `out_valid = nbits>=16`; `flush` → FLUSH.
  - FLUSH: no pops; `out_valid = nbits>0` and `out_data = acc[15:0]` (upper bits zero by the invariant); when `nbits==0` → DONE.
  - DONE: `flush_done=1` for one cycle → RUN.
- `flush` is ignored outside RUN.
- A pop and a `flush` in the same cycle: the pop completes, then FLUSH begins.
- `word_count` increments on each accept, saturates, and clears only on `rst`.
- Reset values: `acc=0`, `nbits=0`, state RUN, `out_valid=0`, `out_data=0`, `fifo_r=0`, `flush_done=0`, `word_count=0`.
- Reset mid-operation discards all buffered bits, aborts any flush without a `flush_done` pulse, and never pops or emits in the reset cycle.

## Timing
- `out_valid` and `out_data` are functions of registers only, with no combinational path from `out_ready`.
- `fifo_r` is the only combinational output, with inputs `fifo_rempty`, `out_ready` and registers.
- `out_data` is stable while `out_valid & !out_ready`.
- Pop-to-word latency: a pixel popped at edge k is visible on `out_data` from cycle k+1 if it completes a word.
- Throughput with `out_ready=1` and the FIFO never empty: steady `nbits` cycle 12→24→20→16→12 gives 4 pops and 3 words per 4 cycles; the block never throttles the FIFO.
- Flush latency:
  - Empty buffer: `flush` sampled at edge k → FLUSH in cycle k+1 → `flush_done` in cycle k+2.
  - Non-empty buffer: `flush_done` is asserted the cycle after the last word is accepted.

## Structure
- Package `pixel_packer_pkg`:
  - Constants: `PixelWidth=12`, `WordWidth=16`, `AccWidth=24`.
  - Typedef: state enum {RUN, FLUSH, DONE}.
- No sub-module; accumulator, control and counter live in one module.

## Test plan
- Push 0x123, 0x456, 0x789, 0xABC with `out_ready=1` → words 0x6123, 0x8945, 0xABC7 in order; `word_count=3`; exactly 4 `fifo_r` pulses.
- Push 0x123, 0x456, then pulse `flush` → words 0x6123 and 0x0045, then a single `flush_done` pulse; state returns to RUN.
- `flush` with an empty buffer → no word; `flush_done` exactly 2 cycles after `flush`.
- FIFO full and `out_ready=0` for 10 cycles → at most 2 pops (`nbits=24`), then `fifo_r=0`; `out_data=0x6123` held stable; on release the stream continues correctly.
- After 3 pixels, assert `rst` for one cycle → `out_valid=0` and `word_count=0` next cycle; pushing 0x123, 0x456, 0x789, 0xABC again yields 0x6123, 0x8945, 0xABC7.
- `WordCountWidth=4`, stream 80 pixels (60 words) → `word_count` holds 15.
